ss_stack_ctrl: RTL

- Responder end of the ss_io stack protocol. Accepts push/pop/pick requests from the execution unit.
- Holds NOS in a visible register `s`; deeper cells live in a synchronous-read RAM. The execution unit keeps TOS itself.
- One instance serves as the data stack; a second instance is planned as the return stack.

---
 rtl/ss_stack_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ss_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ss_stack_ctrl
// Purpose  : Responder end of the ss_io stack protocol. Keeps NOS in the
//            visible register s and the deeper cells in a synchronous-read
//            RAM. TOS is owned by the execution unit. A one-entry prefetch
//            (cell depth-2) lets pops run back-to-back without bubbles.
// Ports    : clk    - system clock, all state changes on posedge
//            rst    - synchronous reset, active-low (0 = reset)
//            en     - request enable, op ignored when 0
//            op     - 0 NOP, 1 PUSH, 2 POP, 3 PICK
//            vi     - value to push
//            idx    - pick index, 0 = NOS
//            s      - current NOS (registered)
//            vo     - pick result
//            vo_vld - one-cycle strobe, vo valid
//            busy   - PICK in flight, non-NOP requests ignored
//            depth  - number of valid cells, 0..DEPTH
//            ovf    - sticky overflow flag
//            udf    - sticky underflow flag
// Options  : SS_CHECK_EN - when defined, $error on every ovf/udf rising edge
//            and assertions on busy / vo_vld pulse widths.
// Revision : 1.0 - initial release
// ============================================================================
module ss_stack_ctrl #(
  parameter int DSZ   = 32,
  parameter int DEPTH = 64,
  parameter int SSZ   = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [1:0]     op,
  input  logic [DSZ-1:0] vi,
  input  logic [SSZ-1:0] idx,
  output logic [DSZ-1:0] s,
  output logic [DSZ-1:0] vo,
  output logic           vo_vld,
  output logic           busy,
  output logic [SSZ:0]   depth,
  output logic           ovf,
  output logic           udf
);

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_PICK = 2'd3
  } stack_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RD   = 1'b1
  } state_e;

  // Source of the pick result, latched when the PICK is accepted
  localparam logic [1:0] PK_NOS = 2'd0;
  localparam logic [1:0] PK_RAM = 2'd1;
  localparam logic [1:0] PK_ERR = 2'd2;

  localparam logic [SSZ:0] FULL = (SSZ+1)'(DEPTH);

  state_e         state, state_nxt;
  stack_op_e      op_e;
  logic [SSZ-1:0] ptr;
  logic           accept, is_full, is_empty;
  logic           push_ok, push_ovf, pop_ok, pop_udf, pick_acc, pick_err;
  logic           ovf_set, udf_set;
  logic [1:0]     pick_kind;

  // RAM and prefetch
  logic [DSZ-1:0] mem [DEPTH];
  logic [DSZ-1:0] rd_data;
  logic [DSZ-1:0] pf_reg;
  logic           pf_sel;   // 1: prefetch lives in rd_data (read issued by a pop)
  logic [DSZ-1:0] pf;
  logic           ram_we, ram_re;
  logic [SSZ-1:0] ram_wa, ram_ra;

  assign op_e     = stack_op_e'(op);
  assign ptr      = depth[SSZ-1:0];
  assign accept   = en & ~busy;
  assign is_full  = (depth == FULL);
  assign is_empty = (depth == '0);

  assign push_ok  = accept & (op_e == OP_PUSH) & ~is_full;
  assign push_ovf = accept & (op_e == OP_PUSH) &  is_full;
  assign pop_ok   = accept & (op_e == OP_POP)  & ~is_empty;
  assign pop_udf  = accept & (op_e == OP_POP)  &  is_empty;
  assign pick_acc = accept & (op_e == OP_PICK);
  assign pick_err = pick_acc & ({1'b0, idx} >= depth);

  assign ovf_set  = push_ovf;
  assign udf_set  = pop_udf | pick_err;

  // Cell k of the stack (0 = bottom) lives at RAM address k; s holds cell
  // depth-1, so the cell just below NOS is at depth-2 and is mirrored in pf.
  assign pf = pf_sel ? rd_data : pf_reg;

  // On a push the old NOS lands at address depth-1. A pop refills the
  // prefetch with cell depth-3; the matching write, if any, was issued at
  // least two cycles earlier, so no RAM forwarding is required.
  assign ram_we = push_ok & ~is_empty;
  assign ram_wa = ptr - SSZ'(1);
  assign ram_re = pop_ok | pick_acc;
  assign ram_ra = pop_ok ? (ptr - SSZ'(3)) : (ptr - SSZ'(1) - idx);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_wa] <= s;
    end
    if (ram_re) begin
      rd_data <= mem[ram_ra];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and busy
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_acc) begin
          state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        busy      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      s         <= '0;
      depth     <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      vo        <= '0;
      vo_vld    <= 1'b0;
      pf_reg    <= '0;
      pf_sel    <= 1'b0;
      pick_kind <= PK_NOS;
    end else begin
      vo_vld <= 1'b0;
      if (ovf_set) begin
        ovf <= 1'b1;
      end
      if (udf_set) begin
        udf <= 1'b1;
      end

      if (push_ok) begin
        s      <= vi;
        depth  <= depth + (SSZ+1)'(1);
        pf_reg <= s;        // old NOS becomes cell depth-2: bypass the RAM
        pf_sel <= 1'b0;
      end else if (pop_ok) begin
        s      <= (depth == (SSZ+1)'(1)) ? '0 : pf;
        depth  <= depth - (SSZ+1)'(1);
        pf_sel <= 1'b1;
      end else if (pick_acc) begin
        // The pick read reuses rd_data, so park the prefetch in pf_reg first
        pf_reg <= pf;
        pf_sel <= 1'b0;
        if (pick_err) begin
          pick_kind <= PK_ERR;
        end else if (idx == '0) begin
          pick_kind <= PK_NOS;
        end else begin
          pick_kind <= PK_RAM;
        end
      end

      if (state == ST_RD) begin
        vo_vld <= 1'b1;
        case (pick_kind)
          PK_NOS:  vo <= s;
          PK_RAM:  vo <= rd_data;
          default: vo <= '0;
        endcase
      end
    end
  end

`ifdef SS_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if (ovf_set && !ovf) begin
        $error("ss_stack_ctrl overflow: op=%0d depth=%0d time=%0t", op, depth, $time);
      end
      if (udf_set && !udf) begin
        $error("ss_stack_ctrl underflow: op=%0d depth=%0d time=%0t", op, depth, $time);
      end
    end
  end

  a_busy_one_cycle: assert property (@(posedge clk) disable iff (!rst) busy |=> !busy);
  a_vld_one_cycle:  assert property (@(posedge clk) disable iff (!rst) vo_vld |=> !vo_vld);
`else
  // Checks disabled: flag logic above is unaffected.
`endif

endmodule
`default_nettype wire
